mem_stage_ctrl: RTL and testbench

- Consumer end of the EX/MEM pipeline register: accepts the latched EX/MEM bundle and drives the data-memory request/ready handshake.
- Resolves the branch (PCSrc).
- Stalls the upstream pipeline while a memory access is outstanding.
- Contains the MEM/WB pipeline register feeding write-back.

---
 rtl/mem_stage_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM-stage controller: data-memory handshake, branch resolve, stall, MEM/WB register
//
// Purpose:
//   Consumes the latched EX/MEM bundle, issues data-memory requests with a
//   request/ready handshake, resolves the branch decision, freezes the
//   upstream pipeline while an access is outstanding and holds the MEM/WB
//   pipeline register that feeds write-back.
//
// Optional feature (macro MEM_MISALIGN_TRAP_EN):
//   defined   - accesses with resultadoALU[1:0] != 0 are trapped: no request,
//               no stall, the instruction becomes a MEM/WB bubble and
//               misalign_out pulses for one cycle.
//   undefined - low address bits pass through unchecked, misalign_out is 0.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   resultadoSL2        branch target from EX/MEM
//   resultadoALU        ALU result / memory address
//   dadoR2              store data
//   rd                  destination register
//   regWrite, branch, memRead, memWrite, memtoReg, zero   EX/MEM control
//   mem_req, mem_we     memory request / write enable (combinational)
//   mem_addr, mem_wdata memory address / write data
//   mem_ready           memory completion pulse
//   mem_rdata           read data, valid with mem_ready
//   PCSrc               branch taken (branch & zero)
//   branch_target       branch destination
//   stall               freeze PC, IF/ID, ID/EX, EX/MEM
//   mem_err             sticky timeout error (registered)
//   misalign_out        misalignment pulse (registered)
//   dadoMem_out, resultadoALU_out, rd_out, regWrite_out, memtoReg_out  MEM/WB

module mem_stage_ctrl #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     resultadoSL2,
  input  logic [DATA_W-1:0]     resultadoALU,
  input  logic [DATA_W-1:0]     dadoR2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  regWrite,
  input  logic                  branch,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic                  memtoReg,
  input  logic                  zero,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  PCSrc,
  output logic [DATA_W-1:0]     branch_target,
  output logic                  stall,
  output logic                  mem_err,
  output logic                  misalign_out,
  output logic [DATA_W-1:0]     dadoMem_out,
  output logic [DATA_W-1:0]     resultadoALU_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  regWrite_out,
  output logic                  memtoReg_out
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ERROR = 2'd2
  } stateT;

  stateT      state, stateNext;
  logic [7:0] cnt, cntNext;

  logic access;
  logic misalign;
  logic accessEff;
  logic busy;

  assign access = memRead | memWrite;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = access & (resultadoALU[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // A trapped access never reaches the memory, so it neither requests nor stalls.
  assign accessEff = access & ~misalign;
  assign busy      = (state == IDLE) | (state == WAIT);

  assign mem_req       = ~reset & accessEff & busy;
  assign mem_we        = mem_req & memWrite;
  assign mem_addr      = resultadoALU;
  assign mem_wdata     = dadoR2;
  assign stall         = (accessEff & busy & ~mem_ready) | (state == ERROR);

  assign PCSrc         = branch & zero;
  assign branch_target = resultadoSL2;

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (accessEff && !mem_ready) begin
          stateNext = WAIT;
          cntNext   = 8'd1;
        end
      end
      WAIT: begin
        if (mem_ready) begin
          stateNext = IDLE;
          cntNext   = 8'd0;
        end else if (cnt == TIMEOUT_C) begin
          stateNext = ERROR;
        end else begin
          cntNext = cnt + 8'd1;
        end
      end
      ERROR: begin
        stateNext = ERROR;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= 8'd0;
      mem_err          <= 1'b0;
      misalign_out     <= 1'b0;
      dadoMem_out      <= '0;
      resultadoALU_out <= '0;
      rd_out           <= '0;
      regWrite_out     <= 1'b0;
      memtoReg_out     <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (stateNext == ERROR) begin
        mem_err <= 1'b1;
      end
      misalign_out <= misalign & ~stall;

      if (!stall && !misalign) begin
        resultadoALU_out <= resultadoALU;
        rd_out           <= rd;
        regWrite_out     <= regWrite;
        memtoReg_out     <= memtoReg;
        // A simultaneous read+write is treated as a write: no load data captured.
        if (memRead && !memWrite && mem_ready) begin
          dadoMem_out <= mem_rdata;
        end
      end else begin
        // Bubble: suppress write-back, keep the rest of MEM/WB unchanged.
        regWrite_out <= 1'b0;
        memtoReg_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - self-checking bench for mem_stage_ctrl

module tb_mem_stage_ctrl;

  logic        clock;
  logic        reset;
  logic [31:0] resultadoSL2, resultadoALU, dadoR2;
  logic [4:0]  rd;
  logic        regWrite, branch, memRead, memWrite, memtoReg, zero;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        PCSrc;
  logic [31:0] branch_target;
  logic        stall, mem_err, misalign_out;
  logic [31:0] dadoMem_out, resultadoALU_out;
  logic [4:0]  rd_out;
  logic        regWrite_out, memtoReg_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] expDado;

  mem_stage_ctrl #(.DATA_W(32), .REG_ADDR_W(5), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .resultadoSL2(resultadoSL2), .resultadoALU(resultadoALU), .dadoR2(dadoR2),
    .rd(rd), .regWrite(regWrite), .branch(branch), .memRead(memRead),
    .memWrite(memWrite), .memtoReg(memtoReg), .zero(zero),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .PCSrc(PCSrc), .branch_target(branch_target), .stall(stall),
    .mem_err(mem_err), .misalign_out(misalign_out),
    .dadoMem_out(dadoMem_out), .resultadoALU_out(resultadoALU_out), .rd_out(rd_out),
    .regWrite_out(regWrite_out), .memtoReg_out(memtoReg_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    resultadoSL2 = '0; resultadoALU = '0; dadoR2 = '0; rd = '0;
    regWrite = 0; branch = 0; memRead = 0; memWrite = 0; memtoReg = 0; zero = 0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    memRead = 1;
    tick();
    tick();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    n_checks++;
    if ({mem_err, misalign_out, regWrite_out, memtoReg_out} !== 4'b0 ||
        dadoMem_out !== 32'h0 || resultadoALU_out !== 32'h0 || rd_out !== 5'h0) begin
      n_fail++;
      $display("FAIL reset_regs got err=%b mis=%b rw=%b m2r=%b dado=%h alu=%h rd=%0d exp all zero",
               mem_err, misalign_out, regWrite_out, memtoReg_out, dadoMem_out, resultadoALU_out, rd_out);
    end
    reset = 0;
    memRead = 0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
    expDado = 32'h0;
  endtask

  task automatic test_load_zero_wait();
    idle_inputs();
    memRead = 1; resultadoALU = 32'h40; mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    rd = 5; regWrite = 1; memtoReg = 1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL load0_stall got=%b exp=0", stall); end
    n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40) begin
      n_fail++; $display("FAIL load0_req got req=%b we=%b addr=%h exp 1 0 00000040", mem_req, mem_we, mem_addr); end
    tick();
    expDado = 32'hDEADBEEF;
    n_checks++; if (dadoMem_out !== expDado) begin n_fail++; $display("FAIL load0_data got=%h exp=%h", dadoMem_out, expDado); end
    n_checks++; if (rd_out !== 5'd5 || regWrite_out !== 1'b1 || memtoReg_out !== 1'b1 || resultadoALU_out !== 32'h40) begin
      n_fail++; $display("FAIL load0_wb got rd=%0d rw=%b m2r=%b alu=%h exp 5 1 1 00000040",
                         rd_out, regWrite_out, memtoReg_out, resultadoALU_out); end
    idle_inputs();
  endtask

  task automatic test_store_wait();
    idle_inputs();
    memWrite = 1; dadoR2 = 32'h1234; resultadoALU = 32'h80; rd = 7;
    for (int c = 0; c < 4; c++) begin
      mem_ready = (c == 3);
      mem_rdata = 32'hBAD0_0000 + 32'(c);
      #1;
      n_checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h1234 || mem_req !== 1'b1) begin
        n_fail++; $display("FAIL store_we c=%0d got we=%b wdata=%h req=%b exp 1 00001234 1", c, mem_we, mem_wdata, mem_req); end
      n_checks++; if (stall !== (c < 3)) begin
        n_fail++; $display("FAIL store_stall c=%0d got=%b exp=%b", c, stall, (c < 3)); end
      tick();
      n_checks++; if (regWrite_out !== 1'b0) begin n_fail++; $display("FAIL store_rw c=%0d got=%b exp=0", c, regWrite_out); end
    end
    n_checks++; if (resultadoALU_out !== 32'h80 || rd_out !== 5'd7 || dadoMem_out !== expDado) begin
      n_fail++; $display("FAIL store_wb got alu=%h rd=%0d dado=%h exp 00000080 7 %h", resultadoALU_out, rd_out, dadoMem_out, expDado); end
    idle_inputs();
  endtask

  task automatic test_timeout();
    idle_inputs();
    memRead = 1; resultadoALU = 32'h60; regWrite = 1; rd = 3;
    #1;
    n_checks++; if (mem_req !== 1'b1 || stall !== 1'b1) begin
      n_fail++; $display("FAIL tmo_start got req=%b stall=%b exp 1 1", mem_req, stall); end
    for (int k = 0; k < 15; k++) tick();
    n_checks++; if (mem_err !== 1'b0 || mem_req !== 1'b1) begin
      n_fail++; $display("FAIL tmo_early got err=%b req=%b exp 0 1", mem_err, mem_req); end
    tick();
    n_checks++; if (mem_err !== 1'b1 || mem_req !== 1'b0 || stall !== 1'b1) begin
      n_fail++; $display("FAIL tmo_error got err=%b req=%b stall=%b exp 1 0 1", mem_err, mem_req, stall); end
    mem_ready = 1; mem_rdata = 32'h5555_AAAA;
    #1;
    n_checks++; if (mem_req !== 1'b0 || stall !== 1'b1) begin
      n_fail++; $display("FAIL tmo_ignore_ready got req=%b stall=%b exp 0 1", mem_req, stall); end
    tick();
    n_checks++; if (mem_err !== 1'b1 || regWrite_out !== 1'b0 || dadoMem_out !== expDado) begin
      n_fail++; $display("FAIL tmo_sticky got err=%b rw=%b dado=%h exp 1 0 %h", mem_err, regWrite_out, dadoMem_out, expDado); end
    reset = 1;
    tick();
    reset = 0;
    idle_inputs();
    expDado = 32'h0;
    #1;
    n_checks++; if (mem_err !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL tmo_reset got err=%b stall=%b exp 0 0", mem_err, stall); end
    memRead = 1; mem_ready = 0;
    #1;
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL tmo_idle_again got req=%b exp 1", mem_req); end
    idle_inputs();
    #1;
  endtask

  task automatic test_branch();
    idle_inputs();
    branch = 1; zero = 1; resultadoSL2 = 32'h100;
    #1;
    n_checks++; if (PCSrc !== 1'b1 || branch_target !== 32'h100) begin
      n_fail++; $display("FAIL branch_taken got pcsrc=%b tgt=%h exp 1 00000100", PCSrc, branch_target); end
    zero = 0;
    #1;
    n_checks++; if (PCSrc !== 1'b0) begin n_fail++; $display("FAIL branch_not_taken got=%b exp=0", PCSrc); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_wait();
    idle_inputs();
    memRead = 1; resultadoALU = 32'h200; rd = 9; regWrite = 1; memtoReg = 1;
    tick();
    tick();
    reset = 1;
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rstwait_req got=%b exp=0", mem_req); end
    tick();
    n_checks++;
    if ({mem_err, misalign_out, regWrite_out, memtoReg_out} !== 4'b0 ||
        dadoMem_out !== 32'h0 || resultadoALU_out !== 32'h0 || rd_out !== 5'h0) begin
      n_fail++;
      $display("FAIL rstwait_regs got err=%b mis=%b rw=%b m2r=%b dado=%h alu=%h rd=%0d exp all zero",
               mem_err, misalign_out, regWrite_out, memtoReg_out, dadoMem_out, resultadoALU_out, rd_out);
    end
    reset = 0;
    expDado = 32'h0;
    mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
    #1;
    n_checks++; if (mem_req !== 1'b1 || stall !== 1'b0) begin
      n_fail++; $display("FAIL rstwait_idle got req=%b stall=%b exp 1 0", mem_req, stall); end
    tick();
    expDado = 32'hCAFE_F00D;
    n_checks++; if (rd_out !== 5'd9 || dadoMem_out !== expDado) begin
      n_fail++; $display("FAIL rstwait_load got rd=%0d dado=%h exp 9 %h", rd_out, dadoMem_out, expDado); end
    idle_inputs();
  endtask

  task automatic test_misalign();
    idle_inputs();
    memRead = 1; resultadoALU = 32'h43; regWrite = 1; memtoReg = 1; rd = 4;
`ifdef MEM_MISALIGN_TRAP_EN
    #1;
    n_checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL misal_req got req=%b stall=%b exp 0 0", mem_req, stall); end
    tick();
    n_checks++; if (misalign_out !== 1'b1 || regWrite_out !== 1'b0 || memtoReg_out !== 1'b0) begin
      n_fail++; $display("FAIL misal_bubble got mis=%b rw=%b m2r=%b exp 1 0 0", misalign_out, regWrite_out, memtoReg_out); end
    idle_inputs();
    tick();
    n_checks++; if (misalign_out !== 1'b0) begin n_fail++; $display("FAIL misal_pulse got=%b exp=0", misalign_out); end
`else
    mem_ready = 1; mem_rdata = 32'h0BAD_CAFE;
    #1;
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h43 || stall !== 1'b0) begin
      n_fail++; $display("FAIL misal_pass got req=%b addr=%h stall=%b exp 1 00000043 0", mem_req, mem_addr, stall); end
    tick();
    expDado = 32'h0BAD_CAFE;
    n_checks++; if (misalign_out !== 1'b0 || regWrite_out !== 1'b1 || dadoMem_out !== expDado) begin
      n_fail++; $display("FAIL misal_off got mis=%b rw=%b dado=%h exp 0 1 %h", misalign_out, regWrite_out, dadoMem_out, expDado); end
    idle_inputs();
`endif
  endtask

  // Transaction-level model: each instruction either passes in one cycle or,
  // for a memory access answered after n idle cycles, stalls exactly n cycles
  // (write-back bubbles meanwhile) and then lands in MEM/WB.
  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int kind, n;
      logic [31:0] addr, wdat, rdat, tgt;
      logic [4:0]  rdv;
      logic rw, m2r, br, z, isAcc, isRead, isWrite;
      kind = int'($urandom_range(0, 3));
      n    = int'($urandom_range(0, 4));
      addr = $urandom & 32'hFFFF_FFFC;
      wdat = $urandom; rdat = $urandom; tgt = $urandom;
      rdv  = 5'($urandom);
      rw   = 1'($urandom); m2r = 1'($urandom); br = 1'($urandom); z = 1'($urandom);
      isRead  = (kind == 1) || (kind == 3);
      isWrite = (kind == 2) || (kind == 3);
      isAcc   = isRead || isWrite;
      if (!isAcc) n = 0;
      resultadoALU = addr; dadoR2 = wdat; resultadoSL2 = tgt; rd = rdv;
      regWrite = rw; memtoReg = m2r; branch = br; zero = z;
      memRead = isRead; memWrite = isWrite;
      for (int c = 0; c <= n; c++) begin
        mem_ready = isAcc ? (c == n) : 1'($urandom);
        mem_rdata = (c == n) ? rdat : $urandom;
        #1;
        n_checks++;
        if (mem_req !== isAcc || mem_we !== (isAcc && isWrite) || stall !== (isAcc && c < n) ||
            PCSrc !== (br && z) || branch_target !== tgt) begin
          n_fail++;
          $display("FAIL rnd_comb i=%0d c=%0d got req=%b we=%b stall=%b pcsrc=%b tgt=%h exp %b %b %b %b %h",
                   i, c, mem_req, mem_we, stall, PCSrc, branch_target,
                   isAcc, (isAcc && isWrite), (isAcc && c < n), (br && z), tgt);
        end
        tick();
        if (c < n) begin
          n_checks++;
          if (regWrite_out !== 1'b0 || memtoReg_out !== 1'b0) begin
            n_fail++; $display("FAIL rnd_bubble i=%0d c=%0d got rw=%b m2r=%b exp 0 0", i, c, regWrite_out, memtoReg_out);
          end
        end else begin
          if (isRead && !isWrite) expDado = rdat;
          n_checks++;
          if (resultadoALU_out !== addr || rd_out !== rdv || regWrite_out !== rw ||
              memtoReg_out !== m2r || dadoMem_out !== expDado) begin
            n_fail++;
            $display("FAIL rnd_wb i=%0d got alu=%h rd=%0d rw=%b m2r=%b dado=%h exp %h %0d %b %b %h",
                     i, resultadoALU_out, rd_out, regWrite_out, memtoReg_out, dadoMem_out,
                     addr, rdv, rw, m2r, expDado);
          end
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    expDado = 32'h0;
    test_reset();
    test_load_zero_wait();
    test_store_wait();
    test_branch();
    test_timeout();
    test_reset_mid_wait();
    test_misalign();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
